// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state codes,
// default operand width and counter sizing.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Must hold the value WIDTH, so one bit wider than clog2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Request/response bundle between the execute-stage controller and mult_unit.
interface mult_unit_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full adder cells.
module ripple_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mult_unit.sv
// MULT/MULTU shift-add multiplier: one ripple-adder add per cycle over WIDTH
// iterations, followed by a sign fix-up step, producing the HI/LO pair.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic        clk,
  input logic        rst,
  mult_unit_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic               neg;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] p_fix;

  // Operands are multiplied as unsigned magnitudes; 0x80..0 maps to itself.
  always_comb begin
    mag_a = bus.a;
    mag_b = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) mag_a = ~bus.a + WIDTH'(1);
    if (bus.is_signed && bus.b[WIDTH-1]) mag_b = ~bus.b + WIDTH'(1);
  end

  always_comb begin
    p_fix = p;
    if (neg) p_fix = ~p + (2*WIDTH)'(1);
  end

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      p     <= '0;
      neg   <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mcand <= mag_a;
            p     <= {{WIDTH{1'b0}}, mag_b};
            neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Add-then-shift folded into one write of the (2*WIDTH+1)-bit value.
          if (p[0]) p <= {cout, sum, p[WIDTH-1:1]};
          else      p <= {1'b0, p[2*WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          // Results are registered here so they are already visible in DONE.
          p     <= p_fix;
          hi_q  <= p_fix[2*WIDTH-1:WIDTH];
          lo_q  <= p_fix[WIDTH-1:0];
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN) || (state == ST_FIX);
  assign bus.done = (state == ST_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
